key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_pkg.sv | 8 +
 rtl/key_debounce_ch.sv | 54 +++++
 rtl/key_debounce.sv | 25 ++
 3 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared FSM state encoding and default debounce length for key_debounce.
package key_pkg;
   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] PRESSED      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel with two-flop synchronizer, debounce FSM, counter and edge pulses.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic clean,
   output logic press_pulse,
   output logic release_pulse
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    sync;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] nxt;
   logic          want;
   logic          moving;
   logic          hit;
   // want is the level that would be a change from the current stable side
   always_comb begin
      want   = (state == PRESSED) || (state == RELEASE_WAIT);
      moving = sync[1] == want;
      nxt    = cnt + 1'b1;
      hit    = moving && (nxt == CW'(DEBOUNCE_CYCLES));
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync          <= 2'b11;
         state         <= IDLE;
         cnt           <= '0;
         clean         <= 1'b1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync          <= {sync[0], raw};
         press_pulse   <= hit && !want;
         release_pulse <= hit && want;
         if (!moving) begin
            state <= want ? PRESSED : IDLE;
            cnt   <= '0;
         end else if (hit) begin
            state <= want ? IDLE : PRESSED;
            cnt   <= '0;
            clean <= want;
         end else begin
            state <= want ? RELEASE_WAIT : PRESS_WAIT;
            cnt   <= nxt;
         end
      end
   end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: NUM_KEYS independent debounced active-low key channels with press/release pulses.
module key_debounce
   import key_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_clean,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release
);
   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      key_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
         .clk          (clk),
         .reset_n      (reset_n),
         .raw          (key_raw[g]),
         .clean        (key_clean[g]),
         .press_pulse  (key_press[g]),
         .release_pulse(key_release[g])
      );
   end
endmodule
